// File: rtl/dat_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dat_rx_pkg
// Purpose  : Shared state encoding, CRC16 polynomial and counter sizing for
//            the wide SD DAT receiver.
// Revision : 1.0
// ============================================================================
package dat_rx_pkg;

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_wait_start = 3'd1;
    localparam logic [2:0] c_st_receive    = 3'd2;
    localparam logic [2:0] c_st_crc        = 3'd3;
    localparam logic [2:0] c_st_end_bit    = 3'd4;
    localparam logic [2:0] c_st_done       = 3'd5;

    localparam logic [15:0] c_crc16_poly = 16'h1021;

    // Width needed to count every payload bit of one block on a single lane.
    function automatic int bit_cnt_w(input int block_bytes);
        return $clog2(block_bytes * 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_lane.sv
`default_nettype none
// ============================================================================
// Module   : crc16_lane
// Purpose  : Serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane.
// Revision : 1.0
// ============================================================================
module crc16_lane
    import dat_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        w_fb;

    always_comb begin
        w_fb  = i_bit ^ crc_q[15];
        crc_d = crc_q;
        if (i_clear) begin
            crc_d = 16'h0000;
        end else if (i_enable) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (w_fb ? c_crc16_poly : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/dat_phys_rx_wide.sv
`default_nettype none
// ============================================================================
// Module   : dat_phys_rx_wide
// Purpose  : SD DAT receiver on 1 or 4 lanes: start detect, 32-bit word
//            assembly, end-bit check. Optional CRC16 check: DAT_RX_CRC16_EN.
// Revision : 1.0
// ============================================================================
module dat_phys_rx_wide
    import dat_rx_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int BLOCK_BYTES = 512,
    parameter int BLK_CNT_W   = 4,
    parameter int TO_W        = 16
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 strobe_in,
    input  logic                 ack_in,
    input  logic                 wide_bus,
    input  logic                 multiple,
    input  logic [BLK_CNT_W-1:0] blocks,
    input  logic [TO_W-1:0]      TIMEOUT_REG,
    input  logic [LANES-1:0]     dat_in,
    output logic [31:0]          fifo_data,
    output logic                 fifo_wr,
    output logic                 busy,
    output logic                 complete,
    output logic                 timeout_err,
    output logic                 endbit_err,
    output logic                 crc_err,
    output logic [BLK_CNT_W-1:0] blocks_done
);

    localparam int CNT_W = bit_cnt_w(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] c_last_w1 = CNT_W'(BLOCK_BYTES * 8 - 1);
    localparam logic [CNT_W-1:0] c_last_w4 = CNT_W'(BLOCK_BYTES * 2 - 1);

    logic [2:0]           state_q, state_d;
    logic                 wide_q, wide_d;
    logic                 mult_q, mult_d;
    logic [BLK_CNT_W-1:0] blk_tgt_q, blk_tgt_d;
    logic [BLK_CNT_W-1:0] blocks_done_q, blocks_done_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]           crc_cnt_q, crc_cnt_d;
    logic [31:0]          word_q, word_d;
    logic [31:0]          fifo_data_q, fifo_data_d;
    logic                 fifo_wr_q, fifo_wr_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 endbit_err_q, endbit_err_d;

    logic [3:0]           w_lanes;
    logic                 w_wide_ok;
    logic                 w_start;
    logic                 w_end_bad;
    logic                 w_word_end;
    logic                 w_blk_end;
    logic [BLK_CNT_W-1:0] w_done_inc;
    logic                 w_more;

    // Unused upper lanes of a narrow build read as idle-high.
    generate
        if (LANES == 4) begin : g_wide
            assign w_lanes   = 4'(dat_in);
            assign w_wide_ok = wide_bus;
        end else begin : g_narrow
            assign w_lanes   = {3'b111, dat_in[0]};
            assign w_wide_ok = 1'b0;
        end
    endgenerate

    assign w_start    = wide_q ? (w_lanes == 4'h0) : ~w_lanes[0];
    assign w_end_bad  = wide_q ? (w_lanes != 4'hF) : ~w_lanes[0];
    assign w_word_end = wide_q ? (bit_cnt_q[2:0] == 3'b111) : (bit_cnt_q[4:0] == 5'h1F);
    assign w_blk_end  = (bit_cnt_q == (wide_q ? c_last_w4 : c_last_w1));
    assign w_done_inc = blocks_done_q + BLK_CNT_W'(1);
    assign w_more     = mult_q && (w_done_inc < blk_tgt_q);

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q       <= c_st_idle;
            wide_q        <= 1'b0;
            mult_q        <= 1'b0;
            blk_tgt_q     <= '0;
            blocks_done_q <= '0;
            to_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            crc_cnt_q     <= 4'h0;
            word_q        <= 32'h0;
            fifo_data_q   <= 32'h0;
            fifo_wr_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            endbit_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wide_q        <= wide_d;
            mult_q        <= mult_d;
            blk_tgt_q     <= blk_tgt_d;
            blocks_done_q <= blocks_done_d;
            to_cnt_q      <= to_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            crc_cnt_q     <= crc_cnt_d;
            word_q        <= word_d;
            fifo_data_q   <= fifo_data_d;
            fifo_wr_q     <= fifo_wr_d;
            timeout_err_q <= timeout_err_d;
            endbit_err_q  <= endbit_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:       if (strobe_in) state_d = c_st_wait_start;
            c_st_wait_start: begin
                if (w_start)                        state_d = c_st_receive;
                else if (to_cnt_q == TIMEOUT_REG)   state_d = c_st_done;
            end
            c_st_receive:    if (w_blk_end) state_d = c_st_crc;
            c_st_crc:        if (crc_cnt_q == 4'hF) state_d = c_st_end_bit;
            c_st_end_bit:    state_d = w_more ? c_st_wait_start : c_st_done;
            c_st_done:       if (ack_in) state_d = c_st_idle;
            default:         state_d = c_st_idle;
        endcase
    end

    always_comb begin
        wide_d        = wide_q;
        mult_d        = mult_q;
        blk_tgt_d     = blk_tgt_q;
        blocks_done_d = blocks_done_q;
        to_cnt_d      = to_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        crc_cnt_d     = crc_cnt_q;
        word_d        = word_q;
        fifo_data_d   = fifo_data_q;
        fifo_wr_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        endbit_err_d  = endbit_err_q;
        case (state_q)
            c_st_idle: begin
                if (strobe_in) begin
                    wide_d        = w_wide_ok;
                    mult_d        = multiple;
                    blk_tgt_d     = (blocks == '0) ? BLK_CNT_W'(1) : blocks;
                    blocks_done_d = '0;
                    to_cnt_d      = '0;
                    timeout_err_d = 1'b0;
                    endbit_err_d  = 1'b0;
                end
            end
            c_st_wait_start: begin
                bit_cnt_d = '0;
                crc_cnt_d = 4'h0;
                if (!w_start) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TIMEOUT_REG) timeout_err_d = 1'b1;
                end
            end
            c_st_receive: begin
                word_d    = wide_q ? {word_q[27:0], w_lanes} : {word_q[30:0], w_lanes[0]};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (w_word_end) begin
                    fifo_data_d = word_d;
                    fifo_wr_d   = 1'b1;
                end
            end
            c_st_crc: begin
                crc_cnt_d = crc_cnt_q + 4'h1;
            end
            c_st_end_bit: begin
                if (w_end_bad) endbit_err_d = 1'b1;
                blocks_done_d = w_done_inc;
                to_cnt_d      = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q != c_st_idle);
        complete = (state_q == c_st_done);
    end

    assign fifo_data   = fifo_data_q;
    assign fifo_wr     = fifo_wr_q;
    assign timeout_err = timeout_err_q;
    assign endbit_err  = endbit_err_q;
    assign blocks_done = blocks_done_q;

`ifdef DAT_RX_CRC16_EN
    logic [15:0]      w_crc [LANES];
    logic [LANES-1:0] w_lane_act;
    logic [LANES-1:0] w_mis;
    logic             crc_bad_q, crc_bad_d;
    logic             crc_err_q, crc_err_d;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_crc
            assign w_lane_act[l] = (l == 0) ? 1'b1 : wide_q;
            crc16_lane u_crc (
                .clk      (sd_clock),
                .rst      (reset),
                .i_clear  (state_q == c_st_wait_start),
                .i_enable ((state_q == c_st_receive) && w_lane_act[l]),
                .i_bit    (w_lanes[l]),
                .o_crc    (w_crc[l])
            );
            // Received CRC arrives MSB first, one bit per CRC cycle.
            assign w_mis[l] = w_lane_act[l] && (w_lanes[l] != w_crc[l][4'hF - crc_cnt_q]);
        end
    endgenerate

    always_comb begin
        crc_bad_d = crc_bad_q;
        crc_err_d = crc_err_q;
        if (state_q == c_st_wait_start)                  crc_bad_d = 1'b0;
        else if (state_q == c_st_crc)                    crc_bad_d = crc_bad_q | (|w_mis);
        if ((state_q == c_st_idle) && strobe_in)         crc_err_d = 1'b0;
        else if (state_q == c_st_end_bit)                crc_err_d = crc_err_q | crc_bad_q;
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            crc_bad_q <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            crc_bad_q <= crc_bad_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dat_phys_rx_wide.sv
`default_nettype none
// ============================================================================
// Module   : tb_dat_phys_rx_wide
// Purpose  : Scoreboard bench for dat_phys_rx_wide (4 lanes, 8-byte blocks).
// Revision : 1.0
// ============================================================================
module tb_dat_phys_rx_wide;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe_in = 1'b0;
    logic        ack_in = 1'b0;
    logic        wide_bus = 1'b0;
    logic        multiple = 1'b0;
    logic [3:0]  blocks = 4'd0;
    logic [15:0] timeout_reg = 16'd1000;
    logic [3:0]  dat = 4'hF;
    logic [31:0] fifo_data;
    logic        fifo_wr, busy, complete, timeout_err, endbit_err, crc_err;
    logic [3:0]  blocks_done;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int ncyc = 0;
    int wr_time_last = 0;
    int wr_time_prev = 0;
    logic [31:0] exp_q [$];

`ifdef DAT_RX_CRC16_EN
    localparam logic c_crc_on = 1'b1;
`else
    localparam logic c_crc_on = 1'b0;
`endif

    dat_phys_rx_wide #(
        .LANES(4), .BLOCK_BYTES(8), .BLK_CNT_W(4), .TO_W(16)
    ) dut (
        .sd_clock(clk), .reset(rst), .strobe_in(strobe_in), .ack_in(ack_in),
        .wide_bus(wide_bus), .multiple(multiple), .blocks(blocks),
        .TIMEOUT_REG(timeout_reg), .dat_in(dat), .fifo_data(fifo_data),
        .fifo_wr(fifo_wr), .busy(busy), .complete(complete),
        .timeout_err(timeout_err), .endbit_err(endbit_err), .crc_err(crc_err),
        .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected word.
    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            wr_count++;
            wr_time_prev = wr_time_last;
            wr_time_last = ncyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fifo_unexpected got=%h expected=none", fifo_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (fifo_data !== e) begin
                    failures++;
                    $display("FAIL fifo_word got=%h expected=%h", fifo_data, e);
                end
            end
        end
        ncyc++;
    end

    function automatic logic [15:0] lane_crc(input logic [63:0] p, input bit wide, input int lane);
        logic [15:0] c;
        logic        b;
        c = 16'h0000;
        for (int k = 0; k < (wide ? 16 : 64); k++) begin
            b = wide ? p[60 - 4*k + lane] : p[63 - k];
            c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic go(input bit wide, input bit mult, input logic [3:0] nblk, input logic [15:0] to);
        wide_bus = wide; multiple = mult; blocks = nblk; timeout_reg = to;
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
    endtask

    task automatic ack();
        ack_in = 1'b1;
        @(negedge clk);
        ack_in = 1'b0;
        chk("ack_busy", {31'b0, busy}, 32'd0);
        chk("ack_complete", {31'b0, complete}, 32'd0);
    endtask

    // Drives start bit, payload, CRC and end bit; returns complete as seen
    // just before the end-bit edge.
    task automatic send_block(input logic [63:0] p, input bit wide, input int end_bad_lane,
                              input int crc_flip_lane, output logic pre_complete);
        logic [15:0] crc [4];
        logic [3:0]  v;
        for (int l = 0; l < 4; l++) crc[l] = lane_crc(p, wide, l);
        exp_q.push_back(p[63:32]);
        exp_q.push_back(p[31:0]);
        dat = wide ? 4'h0 : 4'hE;
        @(negedge clk);
        for (int k = 0; k < (wide ? 16 : 64); k++) begin
            dat = wide ? p[63 - 4*k -: 4] : {3'b111, p[63 - k]};
            @(negedge clk);
        end
        for (int j = 0; j < 16; j++) begin
            v = 4'hF;
            for (int l = 0; l < (wide ? 4 : 1); l++)
                v[l] = crc[l][15 - j] ^ ((l == crc_flip_lane) && (j == 5));
            dat = v;
            @(negedge clk);
        end
        v = 4'hF;
        if (end_bad_lane >= 0) v[end_bad_lane] = 1'b0;
        dat = v;
        pre_complete = complete;
        @(negedge clk);
        dat = 4'hF;
    endtask

    initial begin
        logic pre;
        int   n;
        int   wr0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags", {26'b0, busy, complete, fifo_wr, timeout_err, endbit_err, crc_err}, 32'd0);
        chk("rst_data", fifo_data, 32'd0);
        chk("rst_blocks_done", {28'b0, blocks_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Timeout: lane 0 never goes low.
        wr0 = wr_count;
        go(1'b0, 1'b0, 4'd1, 16'd100);
        n = 0;
        while (complete !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 32'd101);
        chk("to_err", {31'b0, timeout_err}, 32'd1);
        chk("to_busy", {31'b0, busy}, 32'd1);
        chk("to_no_wr", wr_count - wr0, 32'd0);
        ack();
        chk("to_err_sticky", {31'b0, timeout_err}, 32'd1);

        // Single 1-bit block; multiple=0 so blocks=3 is ignored.
        go(1'b0, 1'b0, 4'd3, 16'd1000);
        send_block(64'hDEADBEEF_01234567, 1'b0, -1, -1, pre);
        chk("w1_pre_complete", {31'b0, pre}, 32'd0);
        chk("w1_complete", {31'b0, complete}, 32'd1);
        chk("w1_blocks_done", {28'b0, blocks_done}, 32'd1);
        chk("w1_errs", {29'b0, timeout_err, endbit_err, crc_err}, 32'd0);
        ack();

        // Same payload on 4 lanes.
        go(1'b1, 1'b0, 4'd1, 16'd1000);
        send_block(64'hDEADBEEF_01234567, 1'b1, -1, -1, pre);
        chk("w4_pre_complete", {31'b0, pre}, 32'd0);
        chk("w4_complete", {31'b0, complete}, 32'd1);
        chk("w4_word_spacing", wr_time_last - wr_time_prev, 32'd8);
        chk("w4_errs", {29'b0, timeout_err, endbit_err, crc_err}, 32'd0);
        ack();

        // Two blocks on 4 lanes; stray strobe in DONE must be ignored.
        wr0 = wr_count;
        go(1'b1, 1'b1, 4'd2, 16'd1000);
        send_block(64'h0011_2233_4455_6677, 1'b1, -1, -1, pre);
        chk("mb_mid_complete", {31'b0, complete}, 32'd0);
        chk("mb_mid_busy", {31'b0, busy}, 32'd1);
        chk("mb_mid_done", {28'b0, blocks_done}, 32'd1);
        send_block(64'h8899_AABB_CCDD_EEFF, 1'b1, -1, -1, pre);
        chk("mb_complete", {31'b0, complete}, 32'd1);
        chk("mb_blocks_done", {28'b0, blocks_done}, 32'd2);
        repeat (3) @(negedge clk);
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
        chk("mb_held_complete", {31'b0, complete}, 32'd1);
        chk("mb_held_done", {28'b0, blocks_done}, 32'd2);
        chk("mb_wr_count", wr_count - wr0, 32'd4);
        ack();

        // End bit low on lane 2.
        go(1'b1, 1'b0, 4'd1, 16'd1000);
        send_block(64'hCAFEF00D_12345678, 1'b1, 2, -1, pre);
        chk("eb_complete", {31'b0, complete}, 32'd1);
        chk("eb_endbit_err", {31'b0, endbit_err}, 32'd1);
        chk("eb_crc_err", {31'b0, crc_err}, 32'd0);
        ack();

        // One corrupted CRC bit on lane 1.
        go(1'b1, 1'b0, 4'd1, 16'd1000);
        send_block(64'hA5A5_5A5A_0F0F_F0F0, 1'b1, -1, 1, pre);
        chk("crc_complete", {31'b0, complete}, 32'd1);
        chk("crc_endbit_clr", {31'b0, endbit_err}, 32'd0);
        chk("crc_err", {31'b0, crc_err}, {31'b0, c_crc_on});
        ack();

        // Reset after 10 payload bits, then a clean transfer.
        wr0 = wr_count;
        go(1'b0, 1'b0, 4'd1, 16'd1000);
        dat = 4'hE;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dat = {3'b111, k[0]};
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_flags", {26'b0, busy, complete, fifo_wr, timeout_err, endbit_err, crc_err}, 32'd0);
        chk("mid_rst_data", fifo_data, 32'd0);
        chk("mid_rst_blocks_done", {28'b0, blocks_done}, 32'd0);
        chk("mid_rst_no_wr", wr_count - wr0, 32'd0);
        dat = 4'hF;
        rst = 1'b0;
        @(negedge clk);
        go(1'b0, 1'b0, 4'd1, 16'd1000);
        send_block(64'h1357_9BDF_2468_ACE0, 1'b0, -1, -1, pre);
        chk("post_rst_complete", {31'b0, complete}, 32'd1);
        chk("post_rst_done", {28'b0, blocks_done}, 32'd1);
        chk("post_rst_errs", {29'b0, timeout_err, endbit_err, crc_err}, 32'd0);
        ack();

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/dat_phys_rx_wide.md
Name: dat_phys_rx_wide

Overview:
- Parametrised successor to the single-lane SD DAT physical receiver.
- Receives one or more data blocks from the card on 1 or LANES DAT lines, selected at run time.
- Detects the start bit, deserialises the payload into 32-bit words for the RX FIFO, and checks the per-lane end bit.
- Sits between the DAT pads and the data FIFO, under control of the DAT controller (strobe/ack handshake).

Parameters:
- LANES, 4, physical DAT lines (legal values 1 or 4).
- BLOCK_BYTES, 512, payload bytes per block (multiple of 4).
- BLK_CNT_W, 4, width of the block count input.
- TO_W, 16, width of the timeout register.

Ports:
- sd_clock  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- strobe_in  in  1  one-cycle start request, honoured only in IDLE.
- ack_in  in  1  controller acknowledges completion.
- wide_bus  in  1  1 = use lanes [3:0], 0 = lane 0 only; forced 0 when LANES=1; sampled on strobe_in.
- multiple  in  1  multi-block transfer enable.
- blocks  in  BLK_CNT_W  number of blocks; 0 is treated as 1.
- TIMEOUT_REG  in  TO_W  start-bit wait limit in cycles.
- dat_in  in  LANES  DAT lines from the pads.
- fifo_data  out  32  assembled word.
- fifo_wr  out  1  one-cycle write strobe for fifo_data.
- busy  out  1  high in every state except IDLE.
- complete  out  1  transfer finished; held until ack_in.
- timeout_err  out  1  sticky error flag.
- endbit_err  out  1  sticky error flag.
- crc_err  out  1  sticky error flag.
- blocks_done  out  BLK_CNT_W  blocks received so far.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- Active width W = wide_bus ? 4 : 1. "Active lanes" means lane 0 only, or lanes 3..0.

State transitions:
- IDLE: on strobe_in:
  - latch wide_bus, blocks and multiple;
  - clear the three error flags and blocks_done;
  - go to WAIT_START on the next cycle with the timeout counter at 0.
- WAIT_START: each cycle:
  - all active lanes 0 -> RECEIVE;
  - else increment the counter; when counter == TIMEOUT_REG, set timeout_err and go to DONE;
  - TIMEOUT_REG = 0 gives a timeout on the first cycle without a start bit.
- RECEIVE:
  - Each cycle, shift W bits MSB-first into the word register; for W=4, lane 3 is the most significant bit of each nibble.
  - After 32/W cycles, the word is complete: fifo_data updates and fifo_wr pulses for exactly one cycle, on the cycle after the last bit is sampled.
  - After BLOCK_BYTES*8/W cycles -> CRC.
- CRC: always 16 cycles, sampling the active lanes (framing is identical whether or not the optional feature is present), then -> END_BIT.
- END_BIT: one cycle:
  - any active lane 0 sets endbit_err;
  - increment blocks_done;
  - if multiple and blocks_done (new value) < latched blocks -> WAIT_START with the timeout counter cleared;
  - else -> DONE.
- DONE: complete=1 and busy=1 until ack_in, then IDLE (complete returns to 0 on the next cycle).

Boundary conditions:
- strobe_in outside IDLE: ignored.
- multiple=0: exactly one block regardless of blocks.
- Errors do not abort the block, except timeout.
- Reset asserted mid-transfer: immediate return to IDLE; no fifo_wr is emitted.
- Partial word at the end of a block: cannot occur, because BLOCK_BYTES is a multiple of 4.
- Error flags and blocks_done: stable until the next accepted strobe_in.

Optional Feature:
- Macro: DAT_RX_CRC16_EN.
- Defined: each active lane has a CRC16 (poly x^16+x^12+x^5+1, init 0x0000) over its payload bits. During CRC, the received 16 bits are compared MSB-first per lane; any mismatch sets crc_err at END_BIT.
- Undefined: CRC bits are sampled and discarded; crc_err is tied 0.

Decomposition:
- Shared package dat_rx_pkg:
  - state encoding (IDLE, WAIT_START, RECEIVE, CRC, END_BIT, DONE);
  - CRC16 polynomial constant;
  - bit counter width derivation $clog2(BLOCK_BYTES*8).
- One sub-module: crc16_lane (serial CRC, inputs clear/enable/bit, output crc[15:0]). It is instantiated LANES times under DAT_RX_CRC16_EN.

Test Plan:
- Timeout path: W=1, TIMEOUT_REG=100, dat_in held 1 -> timeout_err=1 and complete=1 after 101 cycles from strobe_in; no fifo_wr.
- Single block, 1-bit: BLOCK_BYTES=8, payload 0xDEADBEEF_01234567 on lane 0 -> two fifo_wr pulses with data 0xDEADBEEF then 0x01234567; blocks_done=1; no errors.
- Wide bus: same payload on 4 lanes (nibble-striped) -> identical words, each word 8 cycles apart; the block lasts 16+16+1 cycles after the start bit.
- Multi-block: blocks=2, multiple=1, card sends two blocks -> four fifo_wr pulses, blocks_done=2, complete held until ack_in, then busy=0.
- End-bit error: last bit 0 on lane 2 with W=4 -> endbit_err=1, transfer still completes; with DAT_RX_CRC16_EN, a corrupted CRC bit on lane 1 -> crc_err=1.
- Reset mid-RECEIVE (after 10 bits) -> all outputs 0 on the next edge; a new strobe_in then completes a clean transfer.
